// File: rtl/piso_tx_ctrl.sv
// piso_tx_ctrl: sequencer for a parallel-in/serial-out shift register.
// Accepts a word over valid/ready, holds it on par_out, issues one load
// cycle followed by a counted shift window, flags the cycles on which the
// PISO serial output carries a frame bit, then pulses done.
// Optional feature: define PISO_TX_PARITY_EN to append an even-parity bit
// (fed through si) as an extra frame bit.
module piso_tx_ctrl #(
    parameter int WIDTH = 3,
    parameter int GAP   = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] data_in,
    input  logic             valid,
    output logic             ready,
    output logic [WIDTH-1:0] par_out,
    output logic             shift,
    output logic             si,
    output logic             bit_valid,
    output logic [4:0]       bit_cnt,
    output logic             busy,
    output logic             done
);

`ifdef PISO_TX_PARITY_EN
    localparam int N = WIDTH + 1;
`else
    localparam int N = WIDTH;
`endif
    localparam logic [4:0] LAST     = 5'(N - 1);
    localparam logic [3:0] GAP_INIT = 4'((GAP > 0) ? GAP - 1 : 0);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_LOAD  = 2'd1,
        S_SHIFT = 2'd2,
        S_GAP   = 2'd3
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] hold_q, hold_d;
    logic [4:0]       cnt_q, cnt_d;
    logic [3:0]       gap_q, gap_d;
    logic             ready_q, ready_d;
    logic             shift_q, shift_d;
    logic             bit_valid_q, bit_valid_d;
    logic [4:0]       bit_cnt_q, bit_cnt_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
`ifdef PISO_TX_PARITY_EN
    logic             si_q, si_d;
`endif

    // Next-state logic; outputs are derived from the next state so that every
    // output comes straight from a flop.
    always_comb begin
        state_d = state_q;
        hold_d  = hold_q;
        cnt_d   = cnt_q;
        gap_d   = gap_q;
        done_d  = 1'b0;
        case (state_q)
            S_IDLE: begin
                // ready is high throughout IDLE, so valid alone means accept
                if (valid) begin
                    hold_d  = data_in;
                    state_d = S_LOAD;
                end
            end
            S_LOAD: begin
                cnt_d   = 5'd0;
                state_d = S_SHIFT;
            end
            S_SHIFT: begin
                if (cnt_q == LAST) begin
                    done_d = 1'b1;
                    cnt_d  = 5'd0;
                    if (GAP > 0) begin
                        gap_d   = GAP_INIT;
                        state_d = S_GAP;
                    end else begin
                        state_d = S_IDLE;
                    end
                end else begin
                    cnt_d = cnt_q + 5'd1;
                end
            end
            S_GAP: begin
                if (gap_q == 4'd0) state_d = S_IDLE;
                else               gap_d   = gap_q - 4'd1;
            end
            default: state_d = S_IDLE;
        endcase

        ready_d     = (state_d == S_IDLE);
        busy_d      = (state_d != S_IDLE);
        shift_d     = (state_d == S_SHIFT);
        bit_valid_d = (state_d == S_SHIFT);
        bit_cnt_d   = (state_d == S_SHIFT) ? cnt_d : 5'd0;
`ifdef PISO_TX_PARITY_EN
        // Parity bit trails the data bits in on si while the word is in flight
        si_d = ((state_d == S_LOAD) || (state_d == S_SHIFT)) ? ^hold_d : 1'b0;
`endif
    end

    // State and output registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            hold_q      <= '0;
            cnt_q       <= 5'd0;
            gap_q       <= 4'd0;
            ready_q     <= 1'b1;
            shift_q     <= 1'b0;
            bit_valid_q <= 1'b0;
            bit_cnt_q   <= 5'd0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
`ifdef PISO_TX_PARITY_EN
            si_q        <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            hold_q      <= hold_d;
            cnt_q       <= cnt_d;
            gap_q       <= gap_d;
            ready_q     <= ready_d;
            shift_q     <= shift_d;
            bit_valid_q <= bit_valid_d;
            bit_cnt_q   <= bit_cnt_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
`ifdef PISO_TX_PARITY_EN
            si_q        <= si_d;
`endif
        end
    end

    assign ready     = ready_q;
    assign par_out   = hold_q;
    assign shift     = shift_q;
    assign bit_valid = bit_valid_q;
    assign bit_cnt   = bit_cnt_q;
    assign busy      = busy_q;
    assign done      = done_q;
`ifdef PISO_TX_PARITY_EN
    assign si        = si_q;
`else
    assign si        = 1'b0;
`endif

endmodule
